// File: rtl/score_keeper.sv
// Score and best-score tracker for the flappy-bird game: counts pipes cleared by the bird in BCD.
// Define SCORE_BEST_EN to build the best-score register and new_best flag; otherwise both read as 0.
module score_keeper #(
  parameter int N_PIPE   = 3,
  parameter int BIRD_COL = 10,
  parameter int DIGITS   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            scene,
  input  logic [24*N_PIPE-1:0]  pipes,
  output logic [4*DIGITS-1:0]   score_bcd,
  output logic [4*DIGITS-1:0]   best_bcd,
  output logic                  score_pulse,
  output logic                  new_best
);

  typedef enum logic [1:0] {IDLE, RUN, FROZEN} state_t;

  localparam logic [7:0] PASS_FROM = 8'(BIRD_COL - 6);
  localparam logic [7:0] PASS_TO   = 8'(BIRD_COL - 7);

  state_t              state;
  logic [7:0]          prev_pos;
  logic [7:0]          lead_pos;
  logic                pass;
  logic                saturated;
  logic                carry;
  logic [4*DIGITS-1:0] score_next;
  logic                unused_bits;

  assign lead_pos    = pipes[23:16];
  assign unused_bits = ^pipes;

  // The pipe leaves the collision window on the 4->3 step, so each pipe scores exactly once.
  assign pass = (prev_pos == PASS_FROM) && (lead_pos == PASS_TO) &&
                (state == RUN) && (scene == 2'd1);

  always_comb begin
    saturated  = 1'b1;
    carry      = 1'b1;
    score_next = score_bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (score_bcd[4*i +: 4] != 4'd9) saturated = 1'b0;
      if (carry) begin
        if (score_bcd[4*i +: 4] == 4'd9) begin
          score_next[4*i +: 4] = 4'd0;
        end else begin
          score_next[4*i +: 4] = score_bcd[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      score_bcd   <= '0;
      prev_pos    <= 8'hFF;
      score_pulse <= 1'b0;
`ifdef SCORE_BEST_EN
      best_bcd    <= '0;
      new_best    <= 1'b0;
`endif
    end else begin
      prev_pos    <= lead_pos;
      score_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (scene == 2'd1) begin
            state     <= RUN;
            score_bcd <= '0;
`ifdef SCORE_BEST_EN
            new_best  <= 1'b0;
`endif
          end
        end
        RUN: begin
          case (scene)
            2'd0: state <= IDLE;
            2'd1: begin
              if (pass && !saturated) begin
                score_bcd   <= score_next;
                score_pulse <= 1'b1;
              end
            end
            2'd2: begin
              state <= FROZEN;
              // BCD digit order matches numeric order, so a plain unsigned compare suffices.
`ifdef SCORE_BEST_EN
              if (score_bcd > best_bcd) begin
                best_bcd <= score_bcd;
                new_best <= 1'b1;
              end
`endif
            end
            default: state <= RUN;
          endcase
        end
        FROZEN: begin
          if (scene == 2'd0) begin
            state <= IDLE;
          end else if (scene == 2'd1) begin
            state     <= RUN;
            score_bcd <= '0;
`ifdef SCORE_BEST_EN
            new_best  <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SCORE_BEST_EN
  assign best_bcd = '0;
  assign new_best = 1'b0;
`endif

endmodule
